// File: rtl/decoder_n_scan.sv
// rtl/decoder_n_scan.sv - registered binary-to-one-hot decoder with direct and scan modes
module decoder_n_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   out,
  output logic                  out_valid,
  output logic                  scan_wrap
);

  localparam int OUT_W = 2**SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SCAN
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   reload_q, reload_d;
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;

  logic                 accept;
  logic [DWELL_W-1:0]   dwell_m1;
  logic [SEL_W-1:0]     idx_next;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] sel);
    return OUT_W'(1) << sel;
  endfunction

  // Handshake: no new value is taken while a scan is running.
  always_comb begin
    in_ready = en & rst_n & (state_q != ST_SCAN);
  end

  // Dwell of zero behaves as one, so the reload value saturates at zero.
  always_comb begin
    accept   = in_valid & in_ready;
    dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    idx_next = idx_q + SEL_W'(1);
  end

  // Next-state: disable beats accept, accept beats scan advance.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    out_d    = out_q;
    valid_d  = valid_q;
    wrap_d   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      out_d   = '0;
      valid_d = 1'b0;
    end else if (accept) begin
      idx_d   = in_sel;
      out_d   = onehot(in_sel);
      valid_d = 1'b1;
      if (mode) begin
        state_d  = ST_SCAN;
        reload_d = dwell_m1;
        cnt_d    = dwell_m1;
      end else begin
        state_d = ST_HOLD;
      end
    end else if (state_q == ST_SCAN) begin
      if (!mode) begin
        // Freeze on the current position; no advance on this edge.
        state_d = ST_HOLD;
      end else if (cnt_q == '0) begin
        idx_d  = idx_next;
        out_d  = onehot(idx_next);
        cnt_d  = reload_q;
        wrap_d = &idx_q;
      end else begin
        cnt_d = cnt_q - DWELL_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      reload_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// tb/tb_decoder_n_scan.sv - self-checking bench for decoder_n_scan
module tb_decoder_n_scan;

  localparam int SEL_W   = 2;
  localparam int DWELL_W = 8;
  localparam int OUT_W   = 2**SEL_W;

  localparam logic [3:0] SCAN_A [12] = '{4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8,
                                         4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2};
  localparam logic [3:0] DW0_A [9]   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1,
                                         4'h2, 4'h4, 4'h8, 4'h1};

  logic               clk = 1'b0;
  logic               rst_n, en, mode, in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic               out_valid, scan_wrap;

  int n_cmp  = 0;
  int n_fail = 0;

  decoder_n_scan #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .dwell     (dwell),
    .out       (out),
    .out_valid (out_valid),
    .scan_wrap (scan_wrap)
  );

  always #5 clk = ~clk;

  // Behavioural model: idle / hold at a position / scan described by
  // start index, dwell and number of edges elapsed since the scan began.
  int m_kind = 0;  // 0 idle, 1 hold, 2 scan
  int m_hpos = 0;
  int m_s0   = 0;
  int m_d    = 1;
  int m_k    = 0;
  bit model_ok = 1'b0;

  function automatic int scan_pos();
    return (m_s0 + m_k / m_d) % OUT_W;
  endfunction

  function automatic logic [OUT_W-1:0] exp_out();
    logic [OUT_W-1:0] r;
    r = '0;
    if (m_kind == 1) r = OUT_W'(1) << m_hpos;
    if (m_kind == 2) r = OUT_W'(1) << scan_pos();
    return r;
  endfunction

  function automatic logic exp_wrap();
    return (m_kind == 2) && (m_k > 0) && (m_k % m_d == 0) && (scan_pos() == 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_kind   = 0;
      model_ok = 1'b1;
    end else if (!en) begin
      m_kind = 0;
    end else if (in_valid && m_kind != 2) begin
      if (!mode) begin
        m_kind = 1;
        m_hpos = int'(in_sel);
      end else begin
        m_kind = 2;
        m_s0   = int'(in_sel);
        m_d    = (dwell == 0) ? 1 : int'(dwell);
        m_k    = 0;
      end
    end else if (m_kind == 2) begin
      if (!mode) begin
        m_hpos = scan_pos();
        m_kind = 1;
      end else begin
        m_k++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("out",       32'(out),       32'(exp_out()));
      chk("out_valid", 32'(out_valid), 32'(m_kind != 0));
      chk("scan_wrap", 32'(scan_wrap), 32'(exp_wrap()));
      chk("in_ready",  32'(in_ready),  32'(en & rst_n & (m_kind != 2)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    mode     = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd3;
    dwell    = 8'd5;
    repeat (3) tick();
    chk("rst_out",      32'(out),       32'h0);
    chk("rst_valid",    32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready),  32'h0);

    rst_n    = 1'b1;
    en       = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'h1);
    chk("rel_out",      32'(out),      32'h0);

    // Direct decode, back-to-back accepts.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      tick();
      chk("direct_out", 32'(out), 32'h1 << i);
    end
    in_valid = 1'b0;
    tick();
    chk("direct_hold", 32'(out), 32'h8);

    // Scan from 2 with dwell 3.
    mode     = 1'b1;
    in_sel   = 2'd2;
    dwell    = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("scan3_out",   32'(out),       32'(SCAN_A[j]));
      chk("scan3_wrap",  32'(scan_wrap), 32'(j == 6));
      chk("scan3_ready", 32'(in_ready),  32'h0);
      tick();
    end

    // Disable mid-scan, then re-enable into idle.
    en = 1'b0;
    tick();
    chk("dis_out",   32'(out),       32'h0);
    chk("dis_valid", 32'(out_valid), 32'h0);
    en = 1'b1;
    #1;
    chk("reen_ready", 32'(in_ready), 32'h1);
    tick();
    chk("reen_out", 32'(out), 32'h0);

    // Scan with dwell 0: advance every cycle.
    mode     = 1'b1;
    in_sel   = 2'd0;
    dwell    = 8'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      chk("scan0_out",  32'(out),       32'(DW0_A[j]));
      chk("scan0_wrap", 32'(scan_wrap), 32'(j == 4 || j == 8));
      tick();
    end

    // Freeze a scan by dropping mode, then direct accept.
    en = 1'b0;
    tick();
    en       = 1'b1;
    in_sel   = 2'd3;
    dwell    = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("pre_freeze_out", 32'(out), 32'h1);
    mode = 1'b0;
    tick();
    chk("freeze_out",   32'(out),       32'h1);
    chk("freeze_ready", 32'(in_ready),  32'h1);
    chk("freeze_wrap",  32'(scan_wrap), 32'h0);
    chk("freeze_valid", 32'(out_valid), 32'h1);
    in_sel   = 2'd1;
    in_valid = 1'b1;
    tick();
    chk("after_freeze", 32'(out), 32'h2);
    in_valid = 1'b0;

    // Reset in the middle of a scan.
    mode     = 1'b1;
    in_sel   = 2'd2;
    dwell    = 8'd2;
    in_valid = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mrst_out",   32'(out),       32'h0);
    chk("mrst_valid", 32'(out_valid), 32'h0);
    chk("mrst_ready", 32'(in_ready),  32'h0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mrst_idle", 32'(out), 32'h0);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom % 64) != 0;
      en       = ($urandom % 16) != 0;
      in_valid = 1'($urandom);
      in_sel   = 2'($urandom);
      dwell    = 8'($urandom_range(0, 4));
      mode     = (m_kind == 2) ? (($urandom % 20) != 0) : 1'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
